// File: rtl/obuf_pkg.sv
// Shared types and sizing helpers for the output-buffer write controller.
// Imported by the position counter and the top-level controller.
package obuf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } obuf_state_e;

    localparam int H_ACT_DEF = 480;
    localparam int V_ACT_DEF = 272;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int addr_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/obuf_pos_cnt.sv
// Column/line position tracker for the incoming pixel stream.
// Reports whether the current pixel is kept and whether it ends the frame.
module obuf_pos_cnt
    import obuf_pkg::*;
#(
    parameter int H_ACT = H_ACT_DEF,
    parameter int V_ACT = V_ACT_DEF,
    parameter int DECIM = 1
) (
    input  logic iClk,
    input  logic iRst,
    input  logic i_restart,
    input  logic i_adv,
    output logic o_keep,
    output logic o_end
);

    localparam int CW = addr_w(H_ACT);
    localparam int LW = addr_w(V_ACT);

    logic [CW-1:0] r_col;
    logic [LW-1:0] r_line;
    logic [CW-1:0] w_col;
    logic [LW-1:0] w_line;
    logic          w_col_last;
    logic          w_line_last;

    // A restart makes the current pixel (0,0) of the new frame.
    assign w_col       = i_restart ? '0 : r_col;
    assign w_line      = i_restart ? '0 : r_line;
    assign w_col_last  = (w_col == CW'(H_ACT - 1));
    assign w_line_last = (w_line == LW'(V_ACT - 1));

    assign o_end  = w_col_last & w_line_last;
    assign o_keep = (DECIM == 1) ? 1'b1 : (~w_col[0] & ~w_line[0]);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_col  <= '0;
            r_line <= '0;
        end else if (i_adv) begin
            if (w_col_last) begin
                r_col  <= '0;
                r_line <= w_line_last ? '0 : w_line + LW'(1);
            end else begin
                r_col  <= w_col + CW'(1);
                r_line <= w_line;
            end
        end else if (i_restart) begin
            r_col  <= '0;
            r_line <= '0;
        end
    end

endmodule

// File: rtl/obuf_wr_ctrl_pp.sv
// Output frame-buffer write controller with ping-pong banks and 2:1 decimation.
// Registers write enable/address/data and publishes the last complete bank.
module obuf_wr_ctrl_pp
    import obuf_pkg::*;
#(
    parameter int H_ACT     = H_ACT_DEF,
    parameter int V_ACT     = V_ACT_DEF,
    parameter int DATA_W    = 16,
    parameter int DECIM     = 1,
    parameter int NUM_BANKS = 2,
    localparam int H_OUT       = H_ACT / DECIM,
    localparam int V_OUT       = V_ACT / DECIM,
    localparam int FRAME_WORDS = H_OUT * V_OUT,
    localparam int ADDR_W      = addr_w(NUM_BANKS * FRAME_WORDS)
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              wEnClk,
    input  logic              wStCnn,
    input  logic              wPxValid,
    input  logic [DATA_W-1:0] wPxDt,
    output logic              wOBufWrEn,
    output logic [ADDR_W-1:0] wOBufWrAddr,
    output logic [DATA_W-1:0] wOBufWrDt,
    output logic              wDispBank,
    output logic              wFrameDone,
    output logic              wFrameErr,
    output logic              wOvf
);

    obuf_state_e       r_state;
    logic [ADDR_W-1:0] r_off;
    logic [ADDR_W-1:0] r_base;
    logic              r_bank;
    logic              r_disp;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_done;
    logic              r_err;
    logic              r_ovf;

    logic              w_st;
    logic              w_px;
    logic              w_take;
    logic              w_keep;
    logic              w_fend;
    logic              w_wr;
    logic              w_end;
    logic [ADDR_W-1:0] w_off;

    assign w_st   = wEnClk & wStCnn;
    assign w_px   = wEnClk & wPxValid;
    assign w_take = w_px & (w_st | (r_state == ST_ACTIVE));
    assign w_wr   = w_take & w_keep;
    assign w_end  = w_take & w_fend;
    assign w_off  = w_st ? '0 : r_off;

    obuf_pos_cnt #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT),
        .DECIM (DECIM)
    ) u_pos (
        .iClk      (iClk),
        .iRst      (iRst),
        .i_restart (w_st),
        .i_adv     (w_take),
        .o_keep    (w_keep),
        .o_end     (w_fend)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= ST_IDLE;
            r_off   <= '0;
            r_base  <= '0;
            r_bank  <= 1'b0;
            r_disp  <= 1'b0;
            r_wr_en <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_wr_en <= w_wr;
            r_done  <= w_end;
            r_err   <= w_st & (r_state == ST_ACTIVE);

            if (w_wr) begin
                r_addr <= r_base + w_off;
                r_data <= wPxDt;
            end

            if (w_end) begin
                r_state <= ST_DONE;
            end else if (w_st) begin
                r_state <= ST_ACTIVE;
            end

            if (w_end) begin
                r_off <= '0;
            end else if (w_wr) begin
                r_off <= w_off + ADDR_W'(1);
            end else if (w_st) begin
                r_off <= '0;
            end

            // Swap to the other bank once a frame is complete.
            if (w_end) begin
                r_disp <= r_bank;
                if (NUM_BANKS == 2) begin
                    r_bank <= ~r_bank;
                    r_base <= r_bank ? '0 : r_base + ADDR_W'(FRAME_WORDS);
                end
            end

            if (w_st) begin
                r_ovf <= 1'b0;
            end else if (w_px && r_state == ST_DONE) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign wOBufWrEn   = r_wr_en;
    assign wOBufWrAddr = r_addr;
    assign wOBufWrDt   = r_data;
    assign wDispBank   = r_disp;
    assign wFrameDone  = r_done;
    assign wFrameErr   = r_err;
    assign wOvf        = r_ovf;

endmodule

// File: tb/tb_obuf_wr_ctrl_pp.sv
// Bench for obuf_wr_ctrl_pp: a full-rate and a 2:1-decimating instance on
// shared stimulus, each checked against a frame-position reference model.
module tb_obuf_wr_ctrl_pp;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int DW = 16;

    logic          iClk = 1'b0;
    logic          iRst;
    logic          wEnClk;
    logic          wStCnn;
    logic          wPxValid;
    logic [DW-1:0] wPxDt;

    logic          a_en, a_disp, a_done, a_err, a_ovf;
    logic [3:0]    a_addr;
    logic [DW-1:0] a_data;
    logic          b_en, b_disp, b_done, b_err, b_ovf;
    logic [1:0]    b_addr;
    logic [DW-1:0] b_data;

    int ncmp = 0;
    int nfail = 0;

    int            mst[2];
    int            mp[2];
    int            mb[2];
    logic          m_en[2];
    int            m_addr[2];
    logic [DW-1:0] m_data[2];
    logic          m_disp[2];
    logic          m_done[2];
    logic          m_err[2];
    logic          m_ovf[2];

    always #5 iClk = ~iClk;

    obuf_wr_ctrl_pp #(
        .H_ACT(H), .V_ACT(V), .DATA_W(DW), .DECIM(1), .NUM_BANKS(2)
    ) u_a (
        .iClk(iClk), .iRst(iRst), .wEnClk(wEnClk), .wStCnn(wStCnn),
        .wPxValid(wPxValid), .wPxDt(wPxDt),
        .wOBufWrEn(a_en), .wOBufWrAddr(a_addr), .wOBufWrDt(a_data),
        .wDispBank(a_disp), .wFrameDone(a_done), .wFrameErr(a_err),
        .wOvf(a_ovf)
    );

    obuf_wr_ctrl_pp #(
        .H_ACT(H), .V_ACT(V), .DATA_W(DW), .DECIM(2), .NUM_BANKS(2)
    ) u_b (
        .iClk(iClk), .iRst(iRst), .wEnClk(wEnClk), .wStCnn(wStCnn),
        .wPxValid(wPxValid), .wPxDt(wPxDt),
        .wOBufWrEn(b_en), .wOBufWrAddr(b_addr), .wOBufWrDt(b_data),
        .wDispBank(b_disp), .wFrameDone(b_done), .wFrameErr(b_err),
        .wOvf(b_ovf)
    );

    function automatic logic [28:0] dut_vec(input int k);
        if (k == 0)
            return {a_en, 4'b0, a_addr, a_data, a_disp, a_done, a_err, a_ovf};
        return {b_en, 6'b0, b_addr, b_data, b_disp, b_done, b_err, b_ovf};
    endfunction

    function automatic logic [28:0] exp_vec(input int k);
        return {m_en[k], 8'(m_addr[k]), m_data[k],
                m_disp[k], m_done[k], m_err[k], m_ovf[k]};
    endfunction

    // Expected outputs after the coming edge, from frame position arithmetic.
    task automatic model_upd();
        for (int k = 0; k < 2; k++) begin
            int d, fw, col, line;
            d  = (k == 0) ? 1 : 2;
            fw = (H / d) * (V / d);
            m_en[k]   = 1'b0;
            m_done[k] = 1'b0;
            m_err[k]  = 1'b0;
            if (iRst) begin
                mst[k] = 0; mp[k] = 0; mb[k] = 0;
                m_addr[k] = 0; m_data[k] = '0;
                m_disp[k] = 1'b0; m_ovf[k] = 1'b0;
            end else if (wEnClk) begin
                if (wStCnn) begin
                    m_err[k] = (mst[k] == 1);
                    mst[k] = 1; mp[k] = 0; m_ovf[k] = 1'b0;
                end
                if (wPxValid) begin
                    if (mst[k] == 1) begin
                        col  = mp[k] % H;
                        line = mp[k] / H;
                        if (d == 1 || (col % 2 == 0 && line % 2 == 0)) begin
                            m_en[k]   = 1'b1;
                            m_addr[k] = mb[k] * fw + (line / d) * (H / d) + col / d;
                            m_data[k] = wPxDt;
                        end
                        if (mp[k] == H * V - 1) begin
                            m_done[k] = 1'b1;
                            m_disp[k] = mb[k][0];
                            mb[k] = 1 - mb[k];
                            mst[k] = 2;
                            mp[k] = 0;
                        end else begin
                            mp[k] = mp[k] + 1;
                        end
                    end else if (mst[k] == 2) begin
                        m_ovf[k] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic st, input logic v, input logic en,
                        input logic [DW-1:0] d);
        wStCnn   = st;
        wPxValid = v;
        wEnClk   = en;
        wPxDt    = d;
        model_upd();
        @(posedge iClk);
        #1;
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        step(0, 1, 1, 16'hffff);
        step(1, 1, 1, 16'h1234);
        for (int k = 0; k < 2; k++) begin
            ncmp++;
            if (dut_vec(k) !== 29'd0) begin
                nfail++;
                $display("FAIL reset[%0d]: got %h want 0", k, dut_vec(k));
            end
        end
        iRst = 1'b0;
        step(0, 0, 1, 0);
    endtask

    task automatic test_frame();
        step(1, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 16'(i + 1));
            ncmp++;
            if ({a_en, a_addr, a_data, a_done} !==
                {1'b1, 4'(i), 16'(i + 1), (i == 7)}) begin
                nfail++;
                $display("FAIL frame1_full px%0d: got en%b a%0d d%h dn%b",
                         i, a_en, a_addr, a_data, a_done);
            end
            ncmp++;
            if ({b_en, b_done} !== {(i == 0 || i == 2), (i == 7)} ||
                (i == 0 && {b_addr, b_data} !== {2'd0, 16'h0001}) ||
                (i == 2 && {b_addr, b_data} !== {2'd1, 16'h0003})) begin
                nfail++;
                $display("FAIL frame1_decim px%0d: got en%b a%0d d%h dn%b",
                         i, b_en, b_addr, b_data, b_done);
            end
        end
        ncmp++;
        if ({a_disp, b_disp} !== 2'b00) begin
            nfail++;
            $display("FAIL frame1_disp: got %b%b want 00", a_disp, b_disp);
        end
        step(1, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 16'($urandom));
            ncmp++;
            if ({a_en, a_addr} !== {1'b1, 4'(8 + i)} ||
                dut_vec(0) !== exp_vec(0)) begin
                nfail++;
                $display("FAIL frame2_full px%0d: got %h want %h",
                         i, dut_vec(0), exp_vec(0));
            end
            ncmp++;
            if (dut_vec(1) !== exp_vec(1)) begin
                nfail++;
                $display("FAIL frame2_decim px%0d: got %h want %h",
                         i, dut_vec(1), exp_vec(1));
            end
        end
        ncmp++;
        if ({a_disp, b_disp} !== 2'b11) begin
            nfail++;
            $display("FAIL frame2_disp: got %b%b want 11", a_disp, b_disp);
        end
    endtask

    task automatic test_enclk();
        step(1, 0, 1, 0);
        for (int i = 0; i < 18; i++) begin
            step(0, 1, (i % 2 == 0), 16'($urandom));
            for (int k = 0; k < 2; k++) begin
                ncmp++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    nfail++;
                    $display("FAIL enclk[%0d] cyc%0d: got %h want %h",
                             k, i, dut_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [1:0] disp_before;
        step(1, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 16'($urandom));
        disp_before = {m_disp[0], m_disp[1]};
        step(1, 0, 1, 0);
        ncmp++;
        if ({a_err, b_err, a_en, b_en} !== 4'b1100) begin
            nfail++;
            $display("FAIL abort_err: got err%b%b en%b%b want err11 en00",
                     a_err, b_err, a_en, b_en);
        end
        step(0, 1, 1, 16'h5a5a);
        ncmp++;
        if ({a_en, a_addr, a_data, a_err} !==
            {1'b1, 4'(mb[0] * 8), 16'h5a5a, 1'b0}) begin
            nfail++;
            $display("FAIL abort_restart: got en%b a%0d d%h e%b want a%0d",
                     a_en, a_addr, a_data, a_err, mb[0] * 8);
        end
        ncmp++;
        if ({a_disp, b_disp} !== disp_before) begin
            nfail++;
            $display("FAIL abort_disp: got %b%b want %b",
                     a_disp, b_disp, disp_before);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 16'($urandom));
            for (int k = 0; k < 2; k++) begin
                ncmp++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    nfail++;
                    $display("FAIL abort_tail[%0d] px%0d: got %h want %h",
                             k, i, dut_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_ovf();
        int nb;
        step(1, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 16'($urandom));
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 16'($urandom));
            ncmp++;
            if ({a_en, b_en, a_ovf, b_ovf} !== 4'b0011) begin
                nfail++;
                $display("FAIL ovf_extra%0d: got en%b%b ovf%b%b want en00 ovf11",
                         i, a_en, b_en, a_ovf, b_ovf);
            end
        end
        nb = mb[0];
        step(1, 1, 1, 16'hbeef);
        ncmp++;
        if ({a_ovf, b_ovf, a_en, a_addr, a_data} !==
            {2'b00, 1'b1, 4'(nb * 8), 16'hbeef}) begin
            nfail++;
            $display("FAIL ovf_clear: got ovf%b%b en%b a%0d d%h want a%0d",
                     a_ovf, b_ovf, a_en, a_addr, a_data, nb * 8);
        end
        for (int k = 0; k < 2; k++) begin
            ncmp++;
            if (dut_vec(k) !== exp_vec(k)) begin
                nfail++;
                $display("FAIL ovf_model[%0d]: got %h want %h",
                         k, dut_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 16'($urandom));
        iRst = 1'b1;
        step(0, 1, 1, 16'h7777);
        for (int k = 0; k < 2; k++) begin
            ncmp++;
            if (dut_vec(k) !== 29'd0) begin
                nfail++;
                $display("FAIL reset_mid[%0d]: got %h want 0", k, dut_vec(k));
            end
        end
        iRst = 1'b0;
        step(1, 1, 1, 16'h0abc);
        ncmp++;
        if ({a_en, a_addr, a_data, a_disp} !== {1'b1, 4'd0, 16'h0abc, 1'b0}) begin
            nfail++;
            $display("FAIL reset_restart: got en%b a%0d d%h disp%b",
                     a_en, a_addr, a_data, a_disp);
        end
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 1, 16'($urandom));
            for (int k = 0; k < 2; k++) begin
                ncmp++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    nfail++;
                    $display("FAIL reset_tail[%0d] px%0d: got %h want %h",
                             k, i, dut_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            iRst = ($urandom_range(0, 199) == 0);
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 3) != 0), 16'($urandom));
            for (int k = 0; k < 2; k++) begin
                ncmp++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    nfail++;
                    $display("FAIL random[%0d] cyc%0d: got %h want %h",
                             k, i, dut_vec(k), exp_vec(k));
                end
            end
        end
        iRst = 1'b0;
    endtask

    initial begin
        iRst = 1'b1;
        wEnClk = 1'b0;
        wStCnn = 1'b0;
        wPxValid = 1'b0;
        wPxDt = '0;
        for (int k = 0; k < 2; k++) begin
            mst[k] = 0; mp[k] = 0; mb[k] = 0;
            m_en[k] = 1'b0; m_addr[k] = 0; m_data[k] = '0;
            m_disp[k] = 1'b0; m_done[k] = 1'b0;
            m_err[k] = 1'b0; m_ovf[k] = 1'b0;
        end
        @(negedge iClk);
        test_reset();
        test_frame();
        test_enclk();
        test_abort();
        test_ovf();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
